// File: rtl/load_unit_ms.sv
// Sequential load unit: word-aligned memory reads over valid/ready, optional
// two-word merge for word-crossing loads, registered extended result.
module load_unit_ms #(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_info,
  input  logic [31:0]       req_alu,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_fault
);

  // Load kinds (funct3 encoding); every other code is a non-load.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the valid side holds its payload stable until that edge.
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        info_q;
  logic [31:0]       lo_q, lo_n;
  logic [31:0]       resp_data_n;
  logic              resp_fault_n;
  logic              cap;
  logic [ADDR_W-1:0] word_addr;

  function automatic logic is_load(input logic [2:0] info);
    is_load = (info == LB) || (info == LH) || (info == LW) ||
              (info == LBU) || (info == LHU);
  endfunction

  function automatic logic [3:0] size_of(input logic [2:0] info);
    case (info)
      LB, LBU: size_of = 4'd1;
      LH, LHU: size_of = 4'd2;
      default: size_of = 4'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [2:0] info);
    crosses = ({2'b00, off} + size_of(info)) > 4'd4;
  endfunction

  // hi is zero for non-crossing loads so the shift pulls in zeros.
  function automatic logic [31:0] form(input logic [2:0] info, input logic [1:0] off,
                                       input logic [31:0] lo, input logic [31:0] hi);
    logic [31:0] w;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (info)
      LB:      form = {{24{w[7]}}, w[7:0]};
      LBU:     form = {24'h0, w[7:0]};
      LH:      form = {{16{w[15]}}, w[15:0]};
      LHU:     form = {16'h0, w[15:0]};
      default: form = w;
    endcase
  endfunction

  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_ready  = (state == IDLE);
  assign mem_valid  = (state == REQ0) || (state == REQ1);
  assign resp_valid = (state == RESP);

  always_comb begin
    mem_addr = '0;
    if (state == REQ0) mem_addr = word_addr;
    else if (state == REQ1) mem_addr = word_addr + ADDR_W'(4);
  end

  always_comb begin
    state_n      = state;
    resp_data_n  = resp_data;
    resp_fault_n = resp_fault;
    lo_n         = lo_q;
    cap          = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cap = 1'b1;
          if (!is_load(req_info)) begin
            state_n      = RESP;
            resp_data_n  = req_alu;
            resp_fault_n = 1'b0;
          end else if (crosses(req_addr[1:0], req_info) && !ALLOW_MISALIGNED) begin
            state_n      = RESP;
            resp_data_n  = 32'h0;
            resp_fault_n = 1'b1;
          end else begin
            state_n = REQ0;
          end
        end
      end
      REQ0: if (mem_ready) state_n = WAIT0;
      WAIT0: begin
        if (mem_rvalid) begin
          lo_n = mem_rdata;
          if (crosses(addr_q[1:0], info_q)) begin
            state_n = REQ1;
          end else begin
            state_n      = RESP;
            resp_data_n  = form(info_q, addr_q[1:0], mem_rdata, 32'h0);
            resp_fault_n = 1'b0;
          end
        end
      end
      REQ1: if (mem_ready) state_n = WAIT1;
      WAIT1: begin
        if (mem_rvalid) begin
          state_n      = RESP;
          resp_data_n  = form(info_q, addr_q[1:0], lo_q, mem_rdata);
          resp_fault_n = 1'b0;
        end
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      info_q     <= 3'b0;
      lo_q       <= 32'h0;
      resp_data  <= 32'h0;
      resp_fault <= 1'b0;
    end else begin
      state      <= state_n;
      lo_q       <= lo_n;
      resp_data  <= resp_data_n;
      resp_fault <= resp_fault_n;
      if (cap) begin
        addr_q <= req_addr;
        info_q <= req_info;
      end
    end
  end

endmodule

// File: tb/tb_load_unit_ms.sv
// Bench for load_unit_ms: a misaligned-capable instance and a faulting instance
// share stimulus; a behavioural memory and byte-level reference model check them.
module tb_load_unit_ms;

  localparam int AW = 32;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, NOP = 3'd3, LBU = 3'd4, LHU = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sel;
  logic          req_valid, mem_ready, mem_rvalid, resp_ready;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_info;
  logic [31:0]   req_alu, mem_rdata;

  logic a_req_ready, a_mem_valid, a_resp_valid, a_resp_fault;
  logic b_req_ready, b_mem_valid, b_resp_valid, b_resp_fault;
  logic [AW-1:0] a_mem_addr, b_mem_addr;
  logic [31:0]   a_resp_data, b_resp_data;

  logic req_ready_s, mem_valid_s, resp_valid_s, resp_fault_s;
  logic [31:0] mem_addr_s, resp_data_s;
  assign req_ready_s  = sel ? b_req_ready  : a_req_ready;
  assign mem_valid_s  = sel ? b_mem_valid  : a_mem_valid;
  assign resp_valid_s = sel ? b_resp_valid : a_resp_valid;
  assign resp_fault_s = sel ? b_resp_fault : a_resp_fault;
  assign mem_addr_s   = sel ? b_mem_addr   : a_mem_addr;
  assign resp_data_s  = sel ? b_resp_data  : a_resp_data;

  load_unit_ms #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_info(req_info), .req_alu(req_alu),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_data(a_resp_data), .resp_fault(a_resp_fault)
  );

  load_unit_ms #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_info(req_info), .req_alu(req_alu),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_data(b_resp_data), .resp_fault(b_resp_fault)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-addressed memory; unwritten words return an address hash.
  logic [31:0] mem_words [logic [31:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Reference: gather bytes one at a time from the byte address space.
  function automatic void ref_load(input logic allow, input logic [31:0] addr,
                                   input logic [2:0] info, input logic [31:0] alu,
                                   output logic [31:0] data, output logic fault,
                                   output int nreq, output logic [31:0] a0, output logic [31:0] a1);
    int size;
    logic [31:0] v, ba, wd;
    data = 32'h0; fault = 1'b0; nreq = 0; a0 = 32'h0; a1 = 32'h0;
    case (info)
      LB, LBU: size = 1;
      LH, LHU: size = 2;
      LW:      size = 4;
      default: size = 0;
    endcase
    if (size == 0) begin
      data = alu;
      return;
    end
    if (int'(addr[1:0]) + size > 4 && !allow) begin
      fault = 1'b1;
      return;
    end
    a0 = {addr[31:2], 2'b00};
    a1 = a0 + 32'd4;
    nreq = (int'(addr[1:0]) + size > 4) ? 2 : 1;
    v = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = addr + 32'(i);
      wd = rd_word({ba[31:2], 2'b00});
      v = v | (((wd >> (8 * int'(ba[1:0]))) & 32'hFF) << (8 * i));
    end
    case (info)
      LB:      data = {{24{v[7]}}, v[7:0]};
      LH:      data = {{16{v[15]}}, v[15:0]};
      default: data = v;
    endcase
  endfunction

  // Drives one request through the selected unit, acting as memory and consumer.
  task automatic run_txn(input logic s, input logic [31:0] addr, input logic [2:0] info,
                         input logic [31:0] alu, input int mstall, input int lat, input int rstall,
                         output logic [31:0] got_data, output logic got_fault, output int got_lat,
                         output int got_nreq, output logic [31:0] got_a0, output logic [31:0] got_a1);
    int n, stall, rleft, wait_ctr;
    bit pending, seen, seen_mv, done, proto_err, mstable_err, rstable_err, rdy_err;
    logic [31:0] pend_addr, held_addr;
    got_data = 32'h0; got_fault = 1'b0; got_lat = -1; got_nreq = 0; got_a0 = 32'h0; got_a1 = 32'h0;
    pending = 0; seen = 0; seen_mv = 0; done = 0;
    proto_err = 0; mstable_err = 0; rstable_err = 0; rdy_err = 0;
    wait_ctr = 0; pend_addr = 32'h0; held_addr = 32'h0;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_addr = addr; req_info = info; req_alu = alu;
    n = 0;
    while (!req_ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_accept", 32'(req_ready_s), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    stall = mstall;
    rleft = rstall;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      mem_rvalid = 1'b0;
      if (pending) begin
        if (wait_ctr == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_word(pend_addr);
          pending = 0;
        end else begin
          wait_ctr--;
        end
      end
      mem_ready = 1'b0;
      if (mem_valid_s) begin
        if (pending || mem_rvalid) begin
          proto_err = 1;
        end else begin
          if (seen_mv && mem_addr_s != held_addr) mstable_err = 1;
          held_addr = mem_addr_s;
          seen_mv = 1;
          if (stall > 0) begin
            stall--;
          end else begin
            mem_ready = 1'b1;
            if (got_nreq == 0) got_a0 = mem_addr_s;
            else got_a1 = mem_addr_s;
            got_nreq++;
            pend_addr = mem_addr_s;
            pending = 1;
            wait_ctr = lat - 1;
            stall = mstall;
            seen_mv = 0;
          end
        end
      end
      resp_ready = 1'b0;
      if (resp_valid_s) begin
        if (!seen) begin
          seen = 1;
          got_lat = cyc + 1;
          got_data = resp_data_s;
          got_fault = resp_fault_s;
        end else if (resp_data_s != got_data || resp_fault_s != got_fault) begin
          rstable_err = 1;
        end
        if (req_ready_s) rdy_err = 1;
        if (rleft > 0) rleft--;
        else begin
          resp_ready = 1'b1;
          done = 1;
        end
      end
      @(negedge clk);
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; resp_ready = 1'b0;
    chk("resp_handshake_done", 32'(done), 32'd1);
    chk("resp_valid_dropped", 32'(resp_valid_s), 32'd0);
    chk("req_ready_after_resp", 32'(req_ready_s), 32'd1);
    chk("mem_valid_in_wait", 32'(proto_err), 32'd0);
    chk("mem_addr_stable", 32'(mstable_err), 32'd0);
    chk("resp_stable", 32'(rstable_err), 32'd0);
    chk("req_ready_low_in_resp", 32'(rdy_err), 32'd0);
    if (!done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] addr;
    logic [2:0]  info;
    logic [31:0] alu, w0, w1;
    int          mstall, lat, rstall;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_nreq;
    logic [31:0] exp_a0, exp_a1;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gd, ed, ea0, ea1, ad;
    logic gf, ef, s;
    int gl, gn, en, el, mst, lt, rs;
    logic [31:0] ga0, ga1;
    logic [2:0] inf;

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; req_info = LW; req_alu = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_a_mem_valid", 32'(a_mem_valid), 32'd0);
    chk("rst_a_mem_addr", a_mem_addr, 32'h0);
    chk("rst_a_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst_a_resp_data", a_resp_data, 32'h0);
    chk("rst_a_resp_fault", 32'(a_resp_fault), 32'd0);
    chk("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    chk("rst_b_resp_valid", 32'(b_resp_valid), 32'd0);
    rst = 1'b0;

    // s addr info alu w0 w1 mstall lat rstall exp_data fault nreq a0 a1 lat
    vecs[0]  = '{1'b0, 32'h100, LW,  32'h0, 32'hDEADBEEF, 32'h0, 0, 1, 0, 32'hDEADBEEF, 1'b0, 1, 32'h100, 32'h0, 3};
    vecs[1]  = '{1'b0, 32'h203, LB,  32'h0, 32'h80112233, 32'h0, 0, 1, 0, 32'hFFFFFF80, 1'b0, 1, 32'h200, 32'h0, 3};
    vecs[2]  = '{1'b0, 32'h203, LBU, 32'h0, 32'h80112233, 32'h0, 0, 1, 0, 32'h00000080, 1'b0, 1, 32'h200, 32'h0, 3};
    vecs[3]  = '{1'b0, 32'h102, LW,  32'h0, 32'h44332211, 32'h88776655, 0, 1, 0, 32'h66554433, 1'b0, 2, 32'h100, 32'h104, 5};
    vecs[4]  = '{1'b0, 32'h103, LHU, 32'h0, 32'h44332211, 32'h88776655, 0, 1, 0, 32'h00005544, 1'b0, 2, 32'h100, 32'h104, 5};
    vecs[5]  = '{1'b0, 32'h103, LH,  32'h0, 32'h44332211, 32'h88776655, 0, 1, 0, 32'h00005544, 1'b0, 2, 32'h100, 32'h104, 5};
    vecs[6]  = '{1'b0, 32'h40,  NOP, 32'h12345678, 32'h0, 32'h0, 0, 1, 0, 32'h12345678, 1'b0, 0, 32'h0, 32'h0, 1};
    vecs[7]  = '{1'b1, 32'h101, LW,  32'h0, 32'h11111111, 32'h22222222, 0, 1, 0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1};
    vecs[8]  = '{1'b1, 32'h40,  3'd7, 32'hCAFEF00D, 32'h0, 32'h0, 0, 1, 0, 32'hCAFEF00D, 1'b0, 0, 32'h0, 32'h0, 1};
    vecs[9]  = '{1'b0, 32'h100, LW,  32'h0, 32'hDEADBEEF, 32'h0, 3, 1, 4, 32'hDEADBEEF, 1'b0, 1, 32'h100, 32'h0, 6};
    vecs[10] = '{1'b0, 32'h102, LH,  32'h0, 32'h80017F00, 32'h0, 0, 1, 0, 32'hFFFF8001, 1'b0, 1, 32'h100, 32'h0, 3};
    vecs[11] = '{1'b0, 32'hFFFFFFFE, LW, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 1, 0, 32'h3344AABB, 1'b0, 2, 32'hFFFFFFFC, 32'h0, 5};
    vecs[12] = '{1'b0, 32'h101, LHU, 32'h0, 32'h00F00D00, 32'h0, 0, 1, 0, 32'h0000F00D, 1'b0, 1, 32'h100, 32'h0, 3};
    vecs[13] = '{1'b1, 32'h200, LW,  32'h0, 32'h80112233, 32'h0, 0, 1, 0, 32'h80112233, 1'b0, 1, 32'h200, 32'h0, 3};
    vecs[14] = '{1'b1, 32'h103, LHU, 32'h0, 32'h44332211, 32'h88776655, 0, 1, 0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1};
    vecs[15] = '{1'b0, 32'h3,   LB,  32'h0, 32'h7F000000, 32'h0, 1, 3, 0, 32'h0000007F, 1'b0, 1, 32'h0, 32'h0, 6};
    vecs[16] = '{1'b0, 32'h105, LW,  32'h0, 32'h04030201, 32'h08070605, 2, 2, 1, 32'h05040302, 1'b0, 2, 32'h104, 32'h108, 11};

    for (int i = 0; i < 17; i++) begin
      mem_words[{vecs[i].addr[31:2], 2'b00}] = vecs[i].w0;
      mem_words[{vecs[i].addr[31:2], 2'b00} + 32'd4] = vecs[i].w1;
      run_txn(vecs[i].s, vecs[i].addr, vecs[i].info, vecs[i].alu, vecs[i].mstall, vecs[i].lat,
              vecs[i].rstall, gd, gf, gl, gn, ga0, ga1);
      chk($sformatf("v%0d_data", i), gd, vecs[i].exp_data);
      chk($sformatf("v%0d_fault", i), 32'(gf), 32'(vecs[i].exp_fault));
      chk($sformatf("v%0d_nreq", i), gn, vecs[i].exp_nreq);
      chk($sformatf("v%0d_latency", i), gl, vecs[i].exp_lat);
      if (vecs[i].exp_nreq > 0) chk($sformatf("v%0d_addr0", i), ga0, vecs[i].exp_a0);
      if (vecs[i].exp_nreq > 1) chk($sformatf("v%0d_addr1", i), ga1, vecs[i].exp_a1);
    end

    // Reset while waiting for the second word of a crossing load.
    mem_words[32'h100] = 32'h44332211;
    mem_words[32'h104] = 32'h88776655;
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_addr = 32'h102; req_info = LW; mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_req0_valid", 32'(a_mem_valid), 32'd1);
    chk("mid_req0_addr", a_mem_addr, 32'h100);
    @(negedge clk);
    chk("mid_wait0_valid", 32'(a_mem_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h44332211;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("mid_req1_valid", 32'(a_mem_valid), 32'd1);
    chk("mid_req1_addr", a_mem_addr, 32'h104);
    @(negedge clk);
    chk("mid_wait1_valid", 32'(a_mem_valid), 32'd0);
    chk("mid_wait1_req_ready", 32'(a_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(a_req_ready), 32'd1);
    chk("mid_rst_mem_valid", 32'(a_mem_valid), 32'd0);
    chk("mid_rst_mem_addr", a_mem_addr, 32'h0);
    chk("mid_rst_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("mid_rst_resp_data", a_resp_data, 32'h0);
    chk("mid_rst_resp_fault", 32'(a_resp_fault), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h88776655;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("late_rvalid_req_ready", 32'(a_req_ready), 32'd1);
    chk("late_rvalid_mem_valid", 32'(a_mem_valid), 32'd0);
    mem_words[32'h100] = 32'hDEADBEEF;
    run_txn(1'b0, 32'h100, LW, 32'h0, 0, 1, 0, gd, gf, gl, gn, ga0, ga1);
    chk("post_rst_data", gd, 32'hDEADBEEF);
    chk("post_rst_nreq", gn, 1);
    chk("post_rst_latency", gl, 3);

    // Randomized traffic against the byte-level model.
    for (int k = 0; k < 200; k++) begin
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       ad = 32'($urandom_range(0, 63));
        1:       ad = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: ad = $urandom;
      endcase
      inf = 3'($urandom_range(0, 7));
      mst = $urandom_range(0, 2);
      lt  = $urandom_range(1, 3);
      rs  = $urandom_range(0, 2);
      ref_load(!s, ad, inf, $urandom, ed, ef, en, ea0, ea1);
      req_alu = ed;
      run_txn(s, ad, inf, ed, mst, lt, rs, gd, gf, gl, gn, ga0, ga1);
      el = (en == 0) ? 1 : 1 + en * (1 + mst + lt);
      chk($sformatf("r%0d_data", k), gd, ed);
      chk($sformatf("r%0d_fault", k), 32'(gf), 32'(ef));
      chk($sformatf("r%0d_nreq", k), gn, en);
      chk($sformatf("r%0d_latency", k), gl, el);
      if (en > 0) chk($sformatf("r%0d_addr0", k), ga0, ea0);
      if (en > 1) chk($sformatf("r%0d_addr1", k), ga1, ea1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
